// File: rtl/ttt_move_ctrl_if.sv
// Button/game-control bundle between the board front panel and ttt_move_ctrl.
// master drives buttons and game controls; slave is the move controller.
interface ttt_move_ctrl_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_place;
    logic       new_game;
    logic       game_over;
    logic [3:0] cell_select;
    logic       place;
    logic       reject;
    logic [8:0] occupied;
    logic [3:0] moves_made;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_place, new_game, game_over,
        input  cell_select, place, reject, occupied, moves_made
    );
    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_place, new_game, game_over,
        output cell_select, place, reject, occupied, moves_made
    );
endinterface

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe input stage: debounced buttons -> 3x3 cursor, place strobe, shadow occupancy.
// Optional macro TTT_AUTO_ADVANCE_EN: after a placement, jump the cursor to the next free cell.
module ttt_btn_db #(
    parameter int DB_CYCLES = 4,
    parameter int CW        = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;

    // Level flips on the sample that would bring the mismatch count to DB_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;
endmodule

module ttt_move_ctrl #(
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    ttt_move_ctrl_if.slave   bus
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REJ, S_HOLD} state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] w_btn, w_lvl, w_rise;
    logic [3:0] w_unused_lvl;
    logic [3:0] r_cell, w_cell_move;
    logic [1:0] w_row, w_col;
    logic [8:0] r_occ;
    logic [3:0] r_moves;

    // Bit order: 0 left, 1 right, 2 up, 3 down, 4 place.
    assign w_btn = {bus.btn_place, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};

    ttt_btn_db #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db [4:0] (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (w_btn),
        .o_level (w_lvl),
        .o_rise  (w_rise)
    );
    assign w_unused_lvl = w_lvl[3:0];

    function automatic logic [1:0] row_of(input logic [3:0] c);
        if (c >= 4'd6) return 2'd2;
        if (c >= 4'd3) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] c);
        logic [3:0] t;
        t = c - 4'd3 * {2'b00, row_of(c)};
        return t[1:0];
    endfunction

    assign w_row = row_of(r_cell);
    assign w_col = col_of(r_cell);

    always_comb begin
        w_cell_move = r_cell;
        if (w_rise[0])      w_cell_move = (w_col == 2'd0) ? r_cell + 4'd2 : r_cell - 4'd1;
        else if (w_rise[1]) w_cell_move = (w_col == 2'd2) ? r_cell - 4'd2 : r_cell + 4'd1;
        else if (w_rise[2]) w_cell_move = (w_row == 2'd0) ? r_cell + 4'd6 : r_cell - 4'd3;
        else if (w_rise[3]) w_cell_move = (w_row == 2'd2) ? r_cell - 4'd6 : r_cell + 4'd3;
    end

`ifdef TTT_AUTO_ADVANCE_EN
    logic [3:0] w_cell_adv;

    // Walk downward so the closest free cell after c (mod 9) is the last one written.
    function automatic logic [3:0] next_free(input logic [3:0] c, input logic [8:0] occ);
        logic [3:0] res;
        logic [4:0] s;
        logic [3:0] idx;
        res = c;
        for (int i = 8; i >= 1; i--) begin
            s   = {1'b0, c} + 5'(i);
            idx = (s >= 5'd9) ? 4'(s - 5'd9) : s[3:0];
            if (!occ[idx]) res = idx;
        end
        return res;
    endfunction

    assign w_cell_adv = next_free(r_cell, r_occ | (9'd1 << r_cell));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise[4]) w_state_nxt = (bus.game_over || r_occ[r_cell]) ? S_REJ : S_ISSUE;
            S_ISSUE: w_state_nxt = S_HOLD;
            S_REJ:   w_state_nxt = S_HOLD;
            S_HOLD:  if (!w_lvl[4]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.new_game) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cell  <= '0;
            r_occ   <= '0;
            r_moves <= '0;
        end else if (bus.new_game) begin
            r_cell  <= '0;
            r_occ   <= '0;
            r_moves <= '0;
        end else begin
            // A place event in the same cycle swallows any cursor move.
            if (r_state == S_IDLE && !w_rise[4]) r_cell <= w_cell_move;
            if (r_state == S_ISSUE) begin
                r_occ[r_cell] <= 1'b1;
                if (r_moves != 4'd9) r_moves <= r_moves + 4'd1;
`ifdef TTT_AUTO_ADVANCE_EN
                r_cell <= w_cell_adv;
`endif
            end
        end
    end

    // Strobes are state decodes so reset or new_game kills them in the same cycle.
    assign bus.place       = (r_state == S_ISSUE) && !bus.new_game;
    assign bus.reject      = (r_state == S_REJ) && !bus.new_game;
    assign bus.cell_select = r_cell;
    assign bus.occupied    = r_occ;
    assign bus.moves_made  = r_moves;
endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Randomized bench for ttt_move_ctrl against a row/col + occupancy-list game model.
module tb_ttt_move_ctrl;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ttt_move_ctrl_if bus();
    ttt_move_ctrl #(.DB_CYCLES(DB)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tot_place = 0, tot_rej = 0, last_place_cyc = -1;
    always @(negedge clk) begin
        if (bus.place) begin
            tot_place      <= tot_place + 1;
            last_place_cyc <= cyc;
        end
        if (bus.reject) tot_rej <= tot_rej + 1;
    end

    int n_chk = 0, n_pass = 0;
    int m_row = 0, m_col = 0, m_moves = 0;
    bit m_occ[9];
    bit m_go = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int m_cell();
        return m_row * 3 + m_col;
    endfunction

    function automatic int m_occ_vec();
        int v = 0;
        for (int i = 0; i < 9; i++) if (m_occ[i]) v += (1 << i);
        return v;
    endfunction

    task automatic m_clear();
        m_row = 0; m_col = 0; m_moves = 0;
        for (int i = 0; i < 9; i++) m_occ[i] = 1'b0;
    endtask

    task automatic set_btns(input logic [4:0] m);
        bus.btn_left = m[0]; bus.btn_right = m[1]; bus.btn_up = m[2];
        bus.btn_down = m[3]; bus.btn_place = m[4];
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, " cell"}, int'(bus.cell_select), m_cell());
        chk({tag, " occ"}, int'(bus.occupied), m_occ_vec());
        chk({tag, " moves"}, int'(bus.moves_made), m_moves);
    endtask

    task automatic m_place();
        int c, j;
        c = m_cell();
        m_occ[c] = 1'b1;
        if (m_moves < 9) m_moves++;
`ifdef TTT_AUTO_ADVANCE_EN
        for (int i = 1; i <= 8; i++) begin
            j = (c + i) % 9;
            if (!m_occ[j]) begin
                m_row = j / 3; m_col = j % 3;
                break;
            end
        end
`endif
    endtask

    // Hold mask for 'hold' cycles, release, let everything settle, then check.
    task automatic press(input logic [4:0] mask, input int hold, input string tag);
        int p0, r0, k, exp_p, exp_r;
        @(posedge clk); #1;
        set_btns(mask);
        k = cyc; p0 = tot_place; r0 = tot_rej;
        repeat (hold) @(posedge clk);
        #1 set_btns(5'd0);
        repeat (DB + 8) @(posedge clk);
        exp_p = 0; exp_r = 0;
        if (hold >= DB) begin
            if (mask[4]) begin
                if (m_go || m_occ[m_cell()]) exp_r = 1;
                else begin exp_p = 1; m_place(); end
            end else if (mask[0]) m_col = (m_col + 2) % 3;
            else if (mask[1])     m_col = (m_col + 1) % 3;
            else if (mask[2])     m_row = (m_row + 2) % 3;
            else if (mask[3])     m_row = (m_row + 1) % 3;
        end
        @(negedge clk);
        chk({tag, " place_cnt"}, tot_place - p0, exp_p);
        chk({tag, " reject_cnt"}, tot_rej - r0, exp_r);
        if (exp_p == 1) chk({tag, " place_lat"}, last_place_cyc - k, DB + 3);
        check_state(tag);
    endtask

    task automatic pulse_new_game(input string tag);
        @(posedge clk); #1 bus.new_game = 1'b1;
        @(posedge clk); #1 bus.new_game = 1'b0;
        m_clear();
        check_state(tag);
    endtask

    task automatic set_go(input bit v);
        @(posedge clk); #1 bus.game_over = v;
        m_go = v;
    endtask

    task automatic rand_dir(input string tag);
        press(5'(1 << $urandom_range(0, 3)), DB + int'($urandom_range(0, 12)), tag);
    endtask

    initial begin
        int p0, r0, guard;
        set_btns(5'd0);
        bus.new_game = 1'b0;
        bus.game_over = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst cell", int'(bus.cell_select), 0);
        chk("rst place", int'(bus.place), 0);
        chk("rst reject", int'(bus.reject), 0);
        chk("rst occ", int'(bus.occupied), 0);
        chk("rst moves", int'(bus.moves_made), 0);
        rst_n = 1'b1;

        press(5'b00010, 20, "right1");
        chk("right1 cell1", int'(bus.cell_select), 1);
        press(5'b00010, 20, "right2");
        press(5'b00010, 20, "right_wrap");
        chk("right wrap cell0", int'(bus.cell_select), 0);
        press(5'b10000, 60, "place0");
        chk("place0 occ", int'(bus.occupied), 1);
        press(5'b10000, 20, "place0_again");
        press(5'b00100, 2, "glitch_up");
        pulse_new_game("ng1");
        press(5'b01000, 20, "down");
        press(5'b00010, 20, "right");
        set_go(1'b1);
        press(5'b10000, 20, "place_gameover");
        set_go(1'b0);
        pulse_new_game("ng2");
        press(5'b01000, 20, "to4_down");
        press(5'b00010, 20, "to4_right");
        press(5'b01001, 20, "left_down");
        chk("left wins cell3", int'(bus.cell_select), 3);
        press(5'b01000, 20, "to6");
        press(5'b00001, 20, "to8");
        press(5'b10000, 20, "place8");

        // new_game in the exact cycle the place event fires
        @(posedge clk); #1 set_btns(5'b10000);
        p0 = tot_place; r0 = tot_rej;
        repeat (DB + 2) @(posedge clk);
        #1 bus.new_game = 1'b1;
        @(posedge clk); #1 bus.new_game = 1'b0;
        repeat (15) @(posedge clk);
        #1 set_btns(5'd0);
        repeat (DB + 8) @(posedge clk);
        m_clear();
        @(negedge clk);
        chk("ng_vs_place place_cnt", tot_place - p0, 0);
        chk("ng_vs_place reject_cnt", tot_rej - r0, 0);
        check_state("ng_vs_place");

        // reset landing on the ISSUE cycle
        @(posedge clk); #1 set_btns(5'b10000);
        p0 = tot_place;
        repeat (DB + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        set_btns(5'd0);
        #1;
        chk("rst_issue place", int'(bus.place), 0);
        chk("rst_issue occ", int'(bus.occupied), 0);
        chk("rst_issue moves", int'(bus.moves_made), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DB + 8) @(posedge clk);
        m_clear();
        @(negedge clk);
        chk("rst_issue place_cnt", tot_place - p0, 0);
        check_state("rst_issue");

        // fill the board, then one more place must be refused
        guard = 0;
        while (m_moves < 9 && guard < 200) begin
            guard++;
            if (m_occ[m_cell()]) rand_dir("fill_move");
            else press(5'b10000, DB + int'($urandom_range(0, 10)), "fill_place");
        end
        chk("fill done", m_moves, 9);
        press(5'b10000, 20, "place_full");
        chk("full moves", int'(bus.moves_made), 9);
        pulse_new_game("ng3");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 7))
                0, 1: rand_dir("rnd_dir");
                2:    press(5'((1 << $urandom_range(0, 3)) | (1 << $urandom_range(0, 3))),
                            DB + int'($urandom_range(0, 8)), "rnd_multi");
                3, 4: press(5'b10000, DB + int'($urandom_range(0, 30)), "rnd_place");
                5:    press(5'(1 << $urandom_range(0, 4)), int'($urandom_range(1, DB - 1)), "rnd_glitch");
                6:    pulse_new_game("rnd_ng");
                default: set_go(~m_go);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ttt_move_ctrl.md
Name: ttt_move_ctrl

Overview:
- Upstream input stage for the tic_tac_toe game core.
- Turns five raw push-buttons (four cursor directions plus place) into a 3x3 cursor position, a stable cell_select and a single-cycle place strobe.
- Keeps a shadow occupancy map, so moves onto occupied cells, or moves made after game over, are rejected before they reach the core.

Parameters:
- DB_CYCLES, default 4: consecutive stable samples needed before a debounced button level changes. Counter width is $clog2(DB_CYCLES+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state.
- btn_left  input  1  raw asynchronous button, active-high.
- btn_right  input  1  raw asynchronous button, active-high.
- btn_up  input  1  raw asynchronous button, active-high.
- btn_down  input  1  raw asynchronous button, active-high.
- btn_place  input  1  raw asynchronous button, active-high.
- new_game  input  1  synchronous; 1 clears the occupancy map and move count and returns the cursor home.
- game_over  input  1  from the core; while 1, place requests are rejected.
- cell_select  output  4  cursor cell index, row*3+col, range 0..8; drives the core.
- place  output  1  single-cycle move strobe to the core.
- reject  output  1  single-cycle pulse when a place request is refused.
- occupied  output  9  shadow map; bit n set means cell n is taken.
- moves_made  output  4  accepted move count, range 0..9.

Behaviour:
- Reset values: cell_select=0, place=0, reject=0, occupied=0, moves_made=0, FSM=IDLE. Synchroniser and debounce state are all cleared.
- Input path for each button:
  - 2-flop synchroniser.
  - Debouncer: the counter increments while the synchronised value differs from the debounced level and clears when they match. When the count reaches DB_CYCLES, the debounced level takes the new value and the counter clears.
  - The rising edge of the debounced level produces a 1-cycle event.
- Latency: for a press held from cycle k, the event is asserted in cycle k+DB_CYCLES+2. place or reject is asserted in cycle k+DB_CYCLES+3.
- Cursor:
  - row and col each range 0..2; cell_select = row*3+col, registered.
  - left/right change col by -1/+1; up/down change row by -1/+1.
  - Wrap-around: col 2 + right gives col 0, and col 0 + left gives col 2. Rows wrap the same way. The other axis is unchanged.
  - If several move events arrive in the same cycle, only one is applied, with priority left > right > up > down. The others are dropped.
  - The cursor only moves while the FSM is in IDLE. Move events in any other state are dropped.
- FSM states: IDLE, ISSUE, REJ, HOLD.
  - IDLE + place event: go to REJ if game_over=1 or occupied[cell_select]=1; otherwise go to ISSUE. A move event in the same cycle is dropped.
  - ISSUE: place=1 for exactly one cycle, with cell_select held stable. occupied[cell_select] is set and moves_made increments (saturating at 9). Then go to HOLD.
  - REJ: reject=1 for one cycle, no state change. Then go to HOLD.
  - HOLD: wait until the debounced btn_place is 0, then go to IDLE. This guarantees at most one move per press.
- new_game=1 overrides everything, in any state, within one cycle: occupied=0, moves_made=0, cursor=0, FSM=IDLE, place=0, reject=0. Debouncer state is kept.
- A new_game that coincides with a place event: new_game wins and the event is discarded.
- When moves_made=9, every cell is occupied, so every place request is rejected.
- Reset asserted mid-operation, including during ISSUE: all outputs go to their reset values immediately. No partial place pulse is allowed to survive.

Optional Feature:
- Macro: TTT_AUTO_ADVANCE_EN.
- With the macro defined: on the cycle after ISSUE, the cursor moves to the lowest-index unoccupied cell above the placed cell, wrapping from 8 to 0. If no cell is free, the cursor stays. This happens in the HOLD entry cycle.
- Without the macro: the cursor stays on the placed cell. No scan logic is synthesised.

Test Plan:
- Reset, then btn_right held for 20 cycles with DB_CYCLES=4 -> exactly one move event, cell_select=1. Two more presses -> 2, then wrap to 0.
- Cursor at cell 0, press btn_place -> place=1 for one cycle at latency DB_CYCLES+3, cell_select=0, occupied=9'b000000001, moves_made=1. Holding the button for 50 more cycles produces no second pulse.
- Press place again on cell 0 -> reject=1 for one cycle, place stays 0, moves_made stays 1.
- Toggle btn_up with a glitch pulse shorter than DB_CYCLES (e.g. 2 cycles) -> no event, cursor unchanged.
- game_over=1, then place on free cell 4 -> reject pulse, occupied unchanged. Then new_game=1 for one cycle -> occupied=0, moves_made=0, cell_select=0.
- btn_left and btn_down rise in the same cycle from cell 4 -> cell_select=3 (left wins). With TTT_AUTO_ADVANCE_EN, placing on cell 8 with cell 0 free -> cursor moves to 0 after the place pulse.
